// File: rtl/rv_alu.sv
// rv_alu -- RV32I integer ALU for the execute stage.
//
// Decodes OP (R-type) and OP-IMM (I-type) instructions and registers the
// result, so rd is valid one cycle after the operands are applied. For
// OP-IMM the decode stage presents the sign-extended immediate on rs2.
// Undecoded opcodes or funct7/funct3 combinations register zero.
//
// Optional feature macro: RV_ALU_MUL_EN
//   Defined   -> OP with funct7 = 0000001 performs MUL/MULH/MULHSU/MULHU
//                (division encodings give zero). Latency stays one cycle.
//   Undefined -> funct7 = 0000001 is undecoded and no multiplier is built.
//
// Ports
//   clk     in   1   clock, rising edge
//   rst     in   1   synchronous active-high reset, clears rd
//   rs1     in   32  operand A
//   rs2     in   32  operand B or sign-extended immediate
//   opcode  in   7   instruction[6:0]
//   funct3  in   3   instruction[14:12]
//   funct7  in   7   instruction[31:25]
//   rd      out  32  registered result

module rv_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic [XLEN-1:0] rd
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [31:0] rd_q;
    logic [31:0] rd_d;

    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;

    assign shamt    = rs2[4:0];
    assign sum      = rs1 + rs2;
    assign diff     = rs1 - rs2;
    assign sll_res  = rs1 << shamt;
    assign srl_res  = rs1 >> shamt;
    assign sra_res  = $unsigned($signed(rs1) >>> shamt);
    assign slt_res  = {31'd0, ($signed(rs1) < $signed(rs2))};
    assign sltu_res = {31'd0, (rs1 < rs2)};

`ifdef RV_ALU_MUL_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Operands extended to 64 bits according to each flavour's signedness;
    // the low 64 bits of an unsigned product of the extended values are the
    // exact two's-complement product, so one unsigned multiply form serves all.
    logic [63:0] prod_ss;
    logic [63:0] prod_su;
    logic [63:0] prod_uu;

    assign prod_ss = {{32{rs1[31]}}, rs1} * {{32{rs2[31]}}, rs2};
    assign prod_su = {{32{rs1[31]}}, rs1} * {32'd0, rs2};
    assign prod_uu = {32'd0, rs1} * {32'd0, rs2};
`endif

    always_comb begin
        rd_d = 32'd0;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000: rd_d = sum;
                        3'b001: rd_d = sll_res;
                        3'b010: rd_d = slt_res;
                        3'b011: rd_d = sltu_res;
                        3'b100: rd_d = rs1 ^ rs2;
                        3'b101: rd_d = srl_res;
                        3'b110: rd_d = rs1 | rs2;
                        3'b111: rd_d = rs1 & rs2;
                        default: rd_d = 32'd0;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        rd_d = diff;
                    end else if (funct3 == 3'b101) begin
                        rd_d = sra_res;
                    end
`ifdef RV_ALU_MUL_EN
                end else if (funct7 == F7_MULDIV) begin
                    unique case (funct3)
                        3'b000: rd_d = prod_uu[31:0];
                        3'b001: rd_d = prod_ss[63:32];
                        3'b010: rd_d = prod_su[63:32];
                        3'b011: rd_d = prod_uu[63:32];
                        default: rd_d = 32'd0;
                    endcase
`endif
                end
            end
            OPC_OP_IMM: begin
                // funct7 only qualifies the immediate shifts.
                unique case (funct3)
                    3'b000: rd_d = sum;
                    3'b001: rd_d = (funct7 == F7_BASE) ? sll_res : 32'd0;
                    3'b010: rd_d = slt_res;
                    3'b011: rd_d = sltu_res;
                    3'b100: rd_d = rs1 ^ rs2;
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            rd_d = srl_res;
                        end else if (funct7 == F7_ALT) begin
                            rd_d = sra_res;
                        end
                    end
                    3'b110: rd_d = rs1 | rs2;
                    3'b111: rd_d = rs1 & rs2;
                    default: rd_d = 32'd0;
                endcase
            end
            default: rd_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 32'd0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_rv_alu.sv
module tb_rv_alu;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rd;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    rv_alu dut (
        .clk    (clk),
        .rst    (rst),
        .rs1    (rs1),
        .rs2    (rs2),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model written from the instruction definitions.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7);
        int unsigned sh;
        logic [31:0] srl_v;
        logic [31:0] sra_v;
        longint      ps;
        longint      psu;
        longint unsigned pu;
        sh    = int'(b[4:0]);
        srl_v = a >> sh;
        sra_v = a[31] ? (srl_v | ~(32'hFFFF_FFFF >> sh)) : srl_v;
        ps    = longint'(signed'(a)) * longint'(signed'(b));
        psu   = longint'(signed'(a)) * longint'({32'd0, b});
        pu    = {32'd0, a} * {32'd0, b};
        if (opc == OP) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: return a + b;
                    3'd1: return a << sh;
                    3'd2: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
                    3'd3: return (a < b) ? 32'd1 : 32'd0;
                    3'd4: return a ^ b;
                    3'd5: return srl_v;
                    3'd6: return a | b;
                    default: return a & b;
                endcase
            end
            if (f7 == 7'h20 && f3 == 3'd0) return a - b;
            if (f7 == 7'h20 && f3 == 3'd5) return sra_v;
`ifdef RV_ALU_MUL_EN
            if (f7 == 7'h01) begin
                case (f3)
                    3'd0: return pu[31:0];
                    3'd1: return ps[63:32];
                    3'd2: return psu[63:32];
                    3'd3: return pu[63:32];
                    default: return 32'd0;
                endcase
            end
`endif
            return 32'd0;
        end
        if (opc == OPI) begin
            case (f3)
                3'd0: return a + b;
                3'd1: return (f7 == 7'h00) ? (a << sh) : 32'd0;
                3'd2: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: return (f7 == 7'h00) ? srl_v : ((f7 == 7'h20) ? sra_v : 32'd0);
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        return 32'd0;
    endfunction

    // Drive one vector, queue its expectation, then retire after the edge.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] exp);
        sb_entry_t e;
        rs1    = a;
        rs2    = b;
        opcode = opc;
        funct3 = f3;
        funct7 = f7;
        sb_q.push_back('{tag, exp});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, rd, e.exp);
        end
    endtask

    logic [31:0] mul_lo, mul_hu, mul_h, mul_hsu;

    initial begin
        rst    = 1'b1;
        rs1    = 32'd5;
        rs2    = 32'd6;
        opcode = OP;
        funct3 = 3'd0;
        funct7 = 7'h00;

        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold", rd, 32'd0);
        end
        rst = 1'b0;
        apply("add_after_reset", 32'd5, 32'd6, OP, 3'd0, 7'h00, 32'd11);

        apply("add",        32'd1,          32'd2,          OP,  3'd0, 7'h00, 32'd3);
        apply("sub_neg",    32'd0,          32'd1,          OP,  3'd0, 7'h20, 32'hFFFF_FFFF);
        apply("add_wrap",   32'hFFFF_FFFF,  32'd1,          OP,  3'd0, 7'h00, 32'd0);
        apply("sra",        32'h8000_0000,  32'h24,         OP,  3'd5, 7'h20, 32'hF800_0000);
        apply("srl",        32'h8000_0000,  32'h24,         OP,  3'd5, 7'h00, 32'h0800_0000);
        apply("slt",        32'hFFFF_FFFF,  32'd1,          OP,  3'd2, 7'h00, 32'd1);
        apply("sltu",       32'hFFFF_FFFF,  32'd1,          OP,  3'd3, 7'h00, 32'd0);
        apply("slti",       32'hFFFF_FFFF,  32'd0,          OPI, 3'd2, 7'h00, 32'd1);
        apply("sll_shamt",  32'd1,          32'h21,         OP,  3'd1, 7'h00, 32'd2);
        apply("xor",        32'hF0F0_F0F0,  32'hFF00_FF00,  OP,  3'd4, 7'h00, 32'h0FF0_0FF0);
        apply("or",         32'h0F0F_0000,  32'h0000_00F0,  OP,  3'd6, 7'h00, 32'h0F0F_00F0);
        apply("and",        32'hF0F0_F0F0,  32'hFF00_FF00,  OP,  3'd7, 7'h00, 32'hF000_F000);
        apply("slli",       32'd3,          32'd4,          OPI, 3'd1, 7'h00, 32'h30);
        apply("slli_badf7", 32'd3,          32'd4,          OPI, 3'd1, 7'h20, 32'd0);
        apply("srai",       32'h8000_0000,  32'd1,          OPI, 3'd5, 7'h20, 32'hC000_0000);
        apply("srli",       32'h8000_0000,  32'd1,          OPI, 3'd5, 7'h00, 32'h4000_0000);
        apply("srli_badf7", 32'h8000_0000,  32'd1,          OPI, 3'd5, 7'h01, 32'd0);
        apply("addi_f7ign", 32'd10,         32'hFFFF_FFFF,  OPI, 3'd0, 7'h7F, 32'd9);
        apply("xori",       32'hAA,         32'hFF,         OPI, 3'd4, 7'h00, 32'h55);
        apply("ori",        32'h1200,       32'h34,         OPI, 3'd6, 7'h00, 32'h1234);
        apply("andi",       32'h1234,       32'h0F0,        OPI, 3'd7, 7'h00, 32'h030);
        apply("sltiu",      32'd1,          32'hFFFF_FFFF,  OPI, 3'd3, 7'h00, 32'd1);
        apply("op_alt_sll", 32'd1,          32'd1,          OP,  3'd1, 7'h20, 32'd0);
        apply("op_alt_slt", 32'd0,          32'd1,          OP,  3'd2, 7'h20, 32'd0);
        apply("op_bad_f7",  32'd1,          32'd2,          OP,  3'd0, 7'h10, 32'd0);
        apply("bad_opcode", 32'd1,          32'd2,          7'h7F, 3'd0, 7'h00, 32'd0);

`ifdef RV_ALU_MUL_EN
        mul_lo  = 32'hFFFF_FFFE;
        mul_hu  = 32'd1;
        mul_h   = 32'hFFFF_FFFF;
        mul_hsu = 32'hFFFF_FFFF;
`else
        mul_lo  = 32'd0;
        mul_hu  = 32'd0;
        mul_h   = 32'd0;
        mul_hsu = 32'd0;
`endif
        apply("mul",    32'hFFFF_FFFF, 32'd2, OP, 3'd0, 7'h01, mul_lo);
        apply("mulhu",  32'hFFFF_FFFF, 32'd2, OP, 3'd3, 7'h01, mul_hu);
        apply("mulh",   32'hFFFF_FFFF, 32'd2, OP, 3'd1, 7'h01, mul_h);
        apply("mulhsu", 32'hFFFF_FFFF, 32'd2, OP, 3'd2, 7'h01, mul_hsu);
        apply("div",    32'd100,       32'd5, OP, 3'd4, 7'h01, 32'd0);

        // Mid-stream reset clears rd, then the first free edge registers inputs.
        rst = 1'b1;
        apply("midstream_rst", 32'd7, 32'd8, OP, 3'd0, 7'h00, 32'd0);
        rst = 1'b0;
        apply("rst_release",   32'd7, 32'd8, OP, 3'd0, 7'h00, 32'd15);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic [6:0]  opc, f7;
            logic [2:0]  f3;
            a   = $urandom();
            b   = $urandom();
            opc = ($urandom_range(0, 1) == 0) ? OP : OPI;
            f3  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            apply("random", a, b, opc, f3, f7, ref_alu(a, b, opc, f3, f7));
        end

        if (sb_q.size() != 0) begin
            chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
